// File: rtl/dht11_responder_if.sv
// Register/line-side bus of the DHT11 sensor emulator: frame bytes, line level and status pulses.
// The master drives the line level, enable and bytes; the responder (slave) reports line drive and status.
interface dht11_responder_if;
    localparam int unsigned BYTE_W = 8;

    logic              enable;
    logic              line_in;
    logic              line_drive_low;
    logic [BYTE_W-1:0] humidity_int;
    logic [BYTE_W-1:0] humidity_dec;
    logic [BYTE_W-1:0] temp_int;
    logic [BYTE_W-1:0] temp_dec;
    logic              busy;
    logic              frame_done;
    logic              collision;

    modport master (
        output enable, line_in, humidity_int, humidity_dec, temp_int, temp_dec,
        input  line_drive_low, busy, frame_done, collision
    );

    modport slave (
        input  enable, line_in, humidity_int, humidity_dec, temp_int, temp_dec,
        output line_drive_low, busy, frame_done, collision
    );
endinterface

// File: rtl/dht11_responder.sv
// Sensor end of the single-wire DHT11 protocol: detects a host start pulse, then sends the
// response preamble and a 40-bit humidity/temperature frame with checksum, aborting on collision.
module dht11_responder #(
    parameter int unsigned CLOCKS_PER_US = 50,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30
) (
    input  logic             clock,
    input  logic             reset_n,
    dht11_responder_if.slave bus
);
    localparam int unsigned PRE_W   = (CLOCKS_PER_US > 1) ? $clog2(CLOCKS_PER_US) : 1;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BIT_W   = 6;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = 40;

    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLOCKS_PER_US - 1);
    localparam logic [CNT_W-1:0] START_MIN   = CNT_W'(START_MIN_US);
    localparam logic [CNT_W-1:0] T_RESP_DLY  = CNT_W'(RESP_DELAY_US);
    localparam logic [CNT_W-1:0] T_RESP_LOW  = CNT_W'(80);
    localparam logic [CNT_W-1:0] T_RESP_HIGH = CNT_W'(80);
    localparam logic [CNT_W-1:0] T_BIT_LOW   = CNT_W'(50);
    localparam logic [CNT_W-1:0] T_BIT_ONE   = CNT_W'(70);
    localparam logic [CNT_W-1:0] T_BIT_ZERO  = CNT_W'(26);
    localparam logic [CNT_W-1:0] T_END_LOW   = CNT_W'(50);
    localparam logic [CNT_W-1:0] T_GUARD     = CNT_W'(2);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_LOW,
        S_RESP_DLY,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 line_meta;
    logic                 line_sync;
    logic [PRE_W-1:0]     pre_cnt;
    logic                 us_tick;
    logic [CNT_W-1:0]     us_cnt;
    logic [CNT_W-1:0]     state_dur;
    logic                 timer_done;
    logic                 abort_c;
    logic                 state_change;
    logic                 frame_load;
    logic                 bit_end;
    logic [BYTE_W-1:0]    checksum;
    logic [FRAME_W-1:0]   shreg;
    logic [BIT_W-1:0]     bit_cnt;

    logic                 drive_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 col_d;
    logic                 drive_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 col_q;

    // Two-flop synchronizer for the asynchronous line level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_meta <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            line_meta <= bus.line_in;
            line_sync <= line_meta;
        end
    end

    // Microsecond timebase; restarts on every state entry so each phase lasts an exact multiple of 1 us.
    assign us_tick      = (pre_cnt == PRE_LAST);
    assign state_change = (state_next != state);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else if (state_change) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else begin
            pre_cnt <= us_tick ? '0 : pre_cnt + PRE_W'(1);
            if (us_tick && (us_cnt != '1)) begin
                us_cnt <= us_cnt + CNT_W'(1);
            end
        end
    end

    // Phase length of the timed states, in microseconds.
    always_comb begin
        state_dur = '0;
        case (state)
            S_RESP_DLY:  state_dur = T_RESP_DLY;
            S_RESP_LOW:  state_dur = T_RESP_LOW;
            S_RESP_HIGH: state_dur = T_RESP_HIGH;
            S_BIT_LOW:   state_dur = T_BIT_LOW;
            S_BIT_HIGH:  state_dur = shreg[FRAME_W-1] ? T_BIT_ONE : T_BIT_ZERO;
            S_END_LOW:   state_dur = T_END_LOW;
            default:     state_dur = '0;
        endcase
    end

    assign timer_done = us_tick && (us_cnt == state_dur - CNT_W'(1));

    // A low level while we release the line means someone else is driving it.
    assign abort_c = ((state == S_RESP_HIGH) || (state == S_BIT_HIGH))
                     && (us_cnt >= T_GUARD) && !line_sync;

    assign checksum = bus.humidity_int + bus.humidity_dec + bus.temp_int + bus.temp_dec;

    assign frame_load = (state == S_HOST_LOW) && (state_next == S_RESP_DLY);
    assign bit_end    = (state == S_BIT_HIGH) && timer_done && !abort_c;

    // Frame shift register, snapshotted at start acceptance and sent MSB first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (frame_load) begin
            shreg   <= {bus.humidity_int, bus.humidity_dec, bus.temp_int, bus.temp_dec, checksum};
            bit_cnt <= '0;
        end else if (bit_end) begin
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!line_sync && bus.enable) begin
                    state_next = S_HOST_LOW;
                end
            end
            S_HOST_LOW: begin
                if (line_sync) begin
                    state_next = (us_cnt >= START_MIN) ? S_RESP_DLY : S_IDLE;
                end
            end
            S_RESP_DLY: begin
                if (timer_done) begin
                    state_next = S_RESP_LOW;
                end
            end
            S_RESP_LOW: begin
                if (timer_done) begin
                    state_next = S_RESP_HIGH;
                end
            end
            S_RESP_HIGH: begin
                if (abort_c) begin
                    state_next = S_IDLE;
                end else if (timer_done) begin
                    state_next = S_BIT_LOW;
                end
            end
            S_BIT_LOW: begin
                if (timer_done) begin
                    state_next = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                if (abort_c) begin
                    state_next = S_IDLE;
                end else if (timer_done) begin
                    state_next = (bit_cnt == LAST_BIT) ? S_END_LOW : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                if (timer_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line drive follows the current state; status flags follow the transition being taken.
    always_comb begin
        drive_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        col_d   = 1'b0;
        drive_d = (state == S_RESP_LOW) || (state == S_BIT_LOW) || (state == S_END_LOW);
        busy_d  = (state_next != S_IDLE) && (state_next != S_HOST_LOW);
        done_d  = (state == S_END_LOW) && (state_next == S_IDLE);
        col_d   = abort_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            drive_q <= drive_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            col_q   <= col_d;
        end
    end

    assign bus.line_drive_low = drive_q;
    assign bus.busy           = busy_q;
    assign bus.frame_done     = done_q;
    assign bus.collision      = col_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: plays the host on a pulled-up line and decodes the emitted waveform.
module tb_dht11_responder;
    localparam int CPU       = 2;
    localparam int START_MIN = 100;
    localparam int RESP_DLY  = 30;
    localparam int NRUNS     = 83;

    logic clk;
    logic rst_n;
    logic host_low;
    int   checks;
    int   failures;

    typedef struct {
        string       name;
        logic [31:0] bytes;
        int          host_us;
        bit          en;
        bit          frame;
        int          col_bit;
        int          rst_bit;
        bit          drop_en;
    } vec_t;

    dht11_responder_if bus();

    // Open-drain line with pull-up: low if either side pulls it.
    assign bus.line_in = ~(bus.line_drive_low | host_low);

    dht11_responder #(
        .CLOCKS_PER_US(CPU),
        .START_MIN_US (START_MIN),
        .RESP_DELAY_US(RESP_DLY)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model_frame(input logic [31:0] b);
        logic [7:0] sum;
        sum = b[31:24] + b[23:16] + b[15:8] + b[7:0];
        return {b, sum};
    endfunction

    // Expected length (cycles) of the i-th alternating low/high segment of the sensor drive.
    function automatic int model_run(input logic [39:0] f, input int i);
        if (i < 2) return 80 * CPU;
        if (i == NRUNS - 1) return 50 * CPU;
        if (i % 2 == 0) return 50 * CPU;
        return (f[39 - (i - 3) / 2] ? 70 : 26) * CPU;
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] bytes, input int host_us,
                                input bit en, input bit frame, input int col_bit,
                                input int rst_bit, input bit drop_en);
        vec_t v;
        v.name = name; v.bytes = bytes; v.host_us = host_us; v.en = en; v.frame = frame;
        v.col_bit = col_bit; v.rst_bit = rst_bit; v.drop_en = drop_en;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int          runs[$];
        int          len, rises, delay, done_cnt, col_cnt, busy_bad, tail, inj_at, inj_end, budget;
        bit          prev, d, busy_first, busy_at_done, busy_seen, rst_done;
        logic [39:0] exp_f, got_f;

        exp_f = model_frame(v.bytes);
        {bus.humidity_int, bus.humidity_dec, bus.temp_int, bus.temp_dec} = v.bytes;
        bus.enable = v.en;
        host_low = 1'b1;
        repeat (v.host_us * CPU) @(negedge clk);
        host_low = 1'b0;

        prev = 1'b0; len = 0; rises = 0; delay = -1; done_cnt = 0; col_cnt = 0; busy_bad = 0;
        tail = 0; inj_at = -1; inj_end = -1; busy_first = 1'b0; busy_at_done = 1'b1;
        busy_seen = 1'b0; rst_done = 1'b0;
        budget = (v.frame || v.col_bit >= 0 || v.rst_bit >= 0) ? 12000 : 400;

        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == inj_at) host_low = 1'b1;
            if (c == inj_end) host_low = 1'b0;
            d = bus.line_drive_low;
            if (d != prev) begin
                if (rises > 0) runs.push_back(len);
                if (d) begin
                    rises++;
                    if (rises == 1) begin
                        delay = c;
                        busy_first = bus.busy;
                        {bus.humidity_int, bus.humidity_dec, bus.temp_int, bus.temp_dec} = ~v.bytes;
                        if (v.drop_en) bus.enable = 1'b0;
                    end
                    if (v.rst_bit >= 0 && rises == v.rst_bit + 2) begin
                        #1 rst_n = 1'b0;
                        #1;
                        check({v.name, " async_release"}, longint'(bus.line_drive_low), 0);
                        check({v.name, " async_busy"}, longint'(bus.busy), 0);
                        rst_done = 1'b1;
                    end
                end else if (v.col_bit >= 0 && rises == v.col_bit + 2) begin
                    inj_at  = c + 10 * CPU;
                    inj_end = inj_at + 20 * CPU;
                end
                len = 1;
            end else begin
                len++;
            end
            prev = d;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.frame_done) begin
                done_cnt++;
                busy_at_done = bus.busy;
            end
            if (bus.collision) col_cnt++;
            if (rises > 0 && done_cnt == 0 && col_cnt == 0 && !bus.busy && !rst_done) busy_bad++;
            if (done_cnt + col_cnt > 0 && !d) tail++;
            if (rst_done || (tail >= 10 && c > inj_end)) break;
        end
        host_low = 1'b0;

        if (v.frame) begin
            check({v.name, " frame_done"}, longint'(done_cnt), 1);
            check({v.name, " collision"}, longint'(col_cnt), 0);
            check({v.name, " resp_delay_ok"},
                  longint'(delay >= RESP_DLY * CPU && delay <= RESP_DLY * CPU + 6), 1);
            check({v.name, " busy_at_start"}, longint'(busy_first), 1);
            check({v.name, " busy_gaps"}, longint'(busy_bad), 0);
            check({v.name, " busy_at_done"}, longint'(busy_at_done), 0);
            check({v.name, " segments"}, longint'(runs.size()), longint'(NRUNS));
            if (runs.size() == NRUNS) begin
                got_f = '0;
                for (int k = 0; k < 40; k++) got_f[39 - k] = (runs[3 + 2 * k] > 48 * CPU);
                check({v.name, " frame_bits"}, longint'(got_f), longint'(exp_f));
                for (int i = 0; i < NRUNS; i++)
                    check($sformatf("%s seg%0d", v.name, i), longint'(runs[i]),
                          longint'(model_run(exp_f, i)));
            end
        end else if (v.col_bit >= 0) begin
            check({v.name, " collision"}, longint'(col_cnt), 1);
            check({v.name, " frame_done"}, longint'(done_cnt), 0);
            check({v.name, " released"}, longint'(bus.line_drive_low), 0);
            check({v.name, " busy_after"}, longint'(bus.busy), 0);
        end else if (v.rst_bit >= 0) begin
            check({v.name, " reset_hit"}, longint'(rst_done), 1);
            check({v.name, " frame_done"}, longint'(done_cnt), 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            check({v.name, " no_drive"}, longint'(rises), 0);
            check({v.name, " no_busy"}, longint'(busy_seen), 0);
            check({v.name, " frame_done"}, longint'(done_cnt), 0);
        end
        repeat (50) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[$];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        host_low = 1'b0;
        bus.enable = 1'b0;
        {bus.humidity_int, bus.humidity_dec, bus.temp_int, bus.temp_dec} = '0;
        repeat (3) @(negedge clk);
        check("reset drive", longint'(bus.line_drive_low), 0);
        check("reset busy", longint'(bus.busy), 0);
        check("reset frame_done", longint'(bus.frame_done), 0);
        check("reset collision", longint'(bus.collision), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        vecs.push_back(mk("basic",       32'h3700_1803,             120, 1'b1, 1'b1, -1, -1, 1'b0));
        vecs.push_back(mk("short_start", $urandom(),                60,  1'b1, 1'b0, -1, -1, 1'b0));
        vecs.push_back(mk("all_ones",    32'hFFFF_FFFF,             120, 1'b1, 1'b1, -1, -1, 1'b0));
        vecs.push_back(mk("disabled",    $urandom(),                120, 1'b0, 1'b0, -1, -1, 1'b0));
        vecs.push_back(mk("below_min",   $urandom(),                98,  1'b1, 1'b0, -1, -1, 1'b0));
        vecs.push_back(mk("collide",     $urandom() | 32'h0200_0000, 120, 1'b1, 1'b0, 6,  -1, 1'b0));
        vecs.push_back(mk("after_col",   $urandom(),                130, 1'b1, 1'b1, -1, -1, 1'b0));
        vecs.push_back(mk("reset_mid",   $urandom(),                110, 1'b1, 1'b0, -1, 20, 1'b0));
        vecs.push_back(mk("after_rst",   $urandom(),                140, 1'b1, 1'b1, -1, -1, 1'b0));
        vecs.push_back(mk("en_drop",     $urandom(),                102, 1'b1, 1'b1, -1, -1, 1'b1));

        foreach (vecs[i]) run_txn(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
